// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int MEM_BITS      = 16;
    localparam int MEM_ADDR_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between port A and port B. Round-robin by default;
// define MEM_ARB_FIXED_PRIO_EN to make port A always win contention.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     a_valid,
    input  logic     b_valid,
    input  port_id_t last_grant,
    output port_id_t winner,
    output logic     grant_valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = a_valid | b_valid;
        winner      = PORT_A;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (!a_valid && b_valid) begin
            winner = PORT_B;
        end
`else
        // Under contention the port that did not win last time goes next.
        if (a_valid && b_valid) begin
            winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_valid) begin
            winner = PORT_B;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port combinational-read memory:
// accept, one ISSUE cycle, then a held response. Option: MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITS      = MEM_BITS,
    parameter int ADDR_BITS = MEM_ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,

    input  logic                 i_a_valid,
    output logic                 o_a_ready,
    input  logic                 i_a_rw,
    input  logic [ADDR_BITS-1:0] i_a_addr,
    input  logic [BITS-1:0]      i_a_wdata,
    output logic                 o_a_rvalid,
    input  logic                 i_a_rready,
    output logic [BITS-1:0]      o_a_rdata,

    input  logic                 i_b_valid,
    output logic                 o_b_ready,
    input  logic                 i_b_rw,
    input  logic [ADDR_BITS-1:0] i_b_addr,
    input  logic [BITS-1:0]      i_b_wdata,
    output logic                 o_b_rvalid,
    input  logic                 i_b_rready,
    output logic [BITS-1:0]      o_b_rdata,

    output logic                 o_mem_rw,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [BITS-1:0]      o_mem_data,
    input  logic [BITS-1:0]      i_mem_data,

    output logic                 o_busy
);

    arb_state_t            state;
    arb_state_t            state_next;
    port_id_t              owner;
    port_id_t              last_grant;
    port_id_t              winner;
    logic                  grant_valid;
    logic                  accept;
    logic                  owner_rready;
    logic                  cmd_rw;
    logic [ADDR_BITS-1:0]  cmd_addr;
    logic [BITS-1:0]       cmd_wdata;
    logic [BITS-1:0]       resp_data;

    mem_arb_pick u_pick (
        .a_valid     (i_a_valid),
        .b_valid     (i_b_valid),
        .last_grant  (last_grant),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    assign accept       = (state == IDLE) && grant_valid;
    assign owner_rready = (owner == PORT_A) ? i_a_rready : i_b_rready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        o_a_ready  = 1'b0;
        o_b_ready  = 1'b0;
        o_a_rvalid = 1'b0;
        o_b_rvalid = 1'b0;
        o_mem_rw   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    o_a_ready  = (winner == PORT_A);
                    o_b_ready  = (winner == PORT_B);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                o_mem_rw   = cmd_rw;
                state_next = RESP;
            end
            RESP: begin
                o_a_rvalid = (owner == PORT_A);
                o_b_rvalid = (owner == PORT_B);
                if (owner_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= PORT_A;
            last_grant <= PORT_B;
            cmd_rw     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_data  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
            if (accept) begin
                owner      <= winner;
                last_grant <= winner;
                cmd_rw     <= (winner == PORT_A) ? i_a_rw    : i_b_rw;
                cmd_addr   <= (winner == PORT_A) ? i_a_addr  : i_b_addr;
                cmd_wdata  <= (winner == PORT_A) ? i_a_wdata : i_b_wdata;
            end
            // For writes this captures the pre-write content at the committing edge.
            if (state == ISSUE) begin
                resp_data <= i_mem_data;
            end
        end
    end

    assign o_mem_addr = cmd_addr;
    assign o_mem_data = cmd_wdata;
    assign o_a_rdata  = resp_data;
    assign o_b_rdata  = resp_data;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bench-side memory, transaction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_mem_arbiter;

    localparam int BITS = 16;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, a_ready, a_rw, a_rvalid, a_rready;
    logic [AW-1:0]   a_addr;
    logic [BITS-1:0] a_wdata, a_rdata;
    logic            b_valid, b_ready, b_rw, b_rvalid, b_rready;
    logic [AW-1:0]   b_addr;
    logic [BITS-1:0] b_wdata, b_rdata;
    logic            mem_rw, busy;
    logic [AW-1:0]   mem_addr;
    logic [BITS-1:0] mem_wdata, mem_rdata;

    logic            pl_en;
    logic [AW-1:0]   pl_addr;
    logic [BITS-1:0] pl_data;
    logic [BITS-1:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_a_valid  (a_valid),
        .o_a_ready  (a_ready),
        .i_a_rw     (a_rw),
        .i_a_addr   (a_addr),
        .i_a_wdata  (a_wdata),
        .o_a_rvalid (a_rvalid),
        .i_a_rready (a_rready),
        .o_a_rdata  (a_rdata),
        .i_b_valid  (b_valid),
        .o_b_ready  (b_ready),
        .i_b_rw     (b_rw),
        .i_b_addr   (b_addr),
        .i_b_wdata  (b_wdata),
        .o_b_rvalid (b_rvalid),
        .i_b_rready (b_rready),
        .o_b_rdata  (b_rdata),
        .o_mem_rw   (mem_rw),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_wdata),
        .i_mem_data (mem_rdata),
        .o_busy     (busy)
    );

    // The memory block: combinational read, write at the edge when rw is high.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_rw) mem[mem_addr] <= mem_wdata;
        if (pl_en)  mem[pl_addr]  <= pl_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit pick_b(input bit av, input bit bv, input bit last_b);
`ifdef MEM_ARB_FIXED_PRIO_EN
        return !av && bv;
`else
        if (av && bv) return !last_b;
        return !av && bv;
`endif
    endfunction

    bit              m_live = 1'b0;
    bit              m_busy, m_owner_b, m_rw, m_last_b;
    int              cyc = 0;
    int              m_acc;
    logic [AW-1:0]   m_addr, m_last_addr;
    logic [BITS-1:0] m_wdata, m_resp, m_last_data;
    logic [BITS-1:0] gold [256];

    always @(negedge clk) begin
        bit iss, resp_ph, any, win_b;
        iss = 1'b0; resp_ph = 1'b0; any = 1'b0; win_b = 1'b0;
        cyc++;
        if (pl_en) gold[pl_addr] = pl_data;
        if (m_live) begin
            iss     = m_busy && (cyc == m_acc + 1);
            resp_ph = m_busy && (cyc >= m_acc + 2);
            any     = !m_busy && (a_valid || b_valid);
            win_b   = pick_b(a_valid, b_valid, m_last_b);
            check("m_busy",     32'(busy),      32'(m_busy));
            check("m_a_ready",  32'(a_ready),   32'(any && !win_b));
            check("m_b_ready",  32'(b_ready),   32'(any && win_b));
            check("m_mem_rw",   32'(mem_rw),    32'(iss && m_rw));
            check("m_mem_addr", 32'(mem_addr),  32'(m_last_addr));
            check("m_mem_data", 32'(mem_wdata), 32'(m_last_data));
            check("m_a_rvalid", 32'(a_rvalid),  32'(resp_ph && !m_owner_b));
            check("m_b_rvalid", 32'(b_rvalid),  32'(resp_ph && m_owner_b));
            if (resp_ph) check("m_rdata", 32'(m_owner_b ? b_rdata : a_rdata), 32'(m_resp));
        end
        if (iss) begin
            m_resp = gold[m_addr];
            if (m_rw) gold[m_addr] = m_wdata;
        end
        if (rst) begin
            m_live = 1'b1; m_busy = 1'b0; m_last_b = 1'b1;
            m_last_addr = '0; m_last_data = '0;
        end else if (m_live) begin
            if (any) begin
                m_busy = 1'b1; m_acc = cyc; m_owner_b = win_b; m_last_b = win_b;
                m_rw    = win_b ? b_rw    : a_rw;
                m_addr  = win_b ? b_addr  : a_addr;
                m_wdata = win_b ? b_wdata : a_wdata;
                m_last_addr = m_addr; m_last_data = m_wdata;
            end else if (resp_ph && (m_owner_b ? b_rready : a_rready)) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [BITS-1:0] data);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", 32'(busy), 32'd0);
        tick;
    endtask

    task automatic req(input bit on_b, input bit rw, input logic [AW-1:0] addr,
                       input logic [BITS-1:0] wdata, output logic [BITS-1:0] rdata,
                       output int rw_cycles);
        rw_cycles = 0;
        if (on_b) begin b_valid = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wdata; end
        else      begin a_valid = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wdata; end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (on_b ? b_ready : a_ready) break;
        end
        check("req_ready", 32'(on_b ? b_ready : a_ready), 32'd1);
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_rw) rw_cycles++;
            if (on_b ? b_rvalid : a_rvalid) break;
        end
        check("req_rvalid", 32'(on_b ? b_rvalid : a_rvalid), 32'd1);
        rdata = on_b ? b_rdata : a_rdata;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BITS-1:0] rd;
        int              rwc;
        string           order;
        string           exp_order;
        int              na, nb;

        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        a_valid = 0; a_rw = 0; a_addr = '0; a_wdata = '0; a_rready = 1'b1;
        b_valid = 0; b_rw = 0; b_addr = '0; b_wdata = '0; b_rready = 1'b1;
        tick;
        tick;
        @(negedge clk);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_mem_rw",   32'(mem_rw),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_mem_data", 32'(mem_wdata), 32'd0);
        check("rst_a_rvalid", 32'(a_rvalid),  32'd0);
        check("rst_b_rvalid", 32'(b_rvalid),  32'd0);
        check("rst_a_ready",  32'(a_ready),   32'd0);
        tick;
        rst = 1'b0;

        preload(8'h00, 16'h0081);
        preload(8'h05, 16'h0000);
        preload(8'h10, 16'h0000);
        for (int i = 0; i < 8; i++) preload(8'h20 + 8'(i), 16'hA000 + 16'(i));

        // Read, port A only
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 8'h00;
        @(negedge clk);
        check("t1_a_ready", 32'(a_ready), 32'd1);
        check("t1_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        @(negedge clk);
        check("t1_mem_addr", 32'(mem_addr), 32'h00);
        check("t1_mem_rw",   32'(mem_rw),   32'd0);
        tick;
        @(negedge clk);
        check("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_a_rdata",  32'(a_rdata),  32'h0081);
        check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
        tick;

        // Write then read, port B
        req(1'b1, 1'b1, 8'h05, 16'h1234, rd, rwc);
        check("t2_wr_rdata",  32'(rd), 32'h0000);
        check("t2_wr_rw_cyc", 32'(rwc), 32'd1);
        req(1'b1, 1'b0, 8'h05, 16'h0000, rd, rwc);
        check("t2_rd_rdata",  32'(rd), 32'h1234);
        check("t2_rd_rw_cyc", 32'(rwc), 32'd0);

        // Contention: both ports hold valid for 4 reads each
        order = ""; na = 0; nb = 0;
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 8'h20;
        b_valid = 1'b1; b_rw = 1'b0; b_addr = 8'h24;
        for (int c = 0; c < 100 && (na < 4 || nb < 4); c++) begin
            @(negedge clk);
            if (a_valid && a_ready) begin order = {order, "A"}; na++; end
            if (b_valid && b_ready) begin order = {order, "B"}; nb++; end
            tick;
            a_addr = 8'h20 + 8'(na);
            b_addr = 8'h24 + 8'(nb);
            if (na >= 4) a_valid = 1'b0;
            if (nb >= 4) b_valid = 1'b0;
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = "AAAABBBB";
`else
        exp_order = "ABABABAB";
`endif
        tests++;
        if (order != exp_order) begin
            fails++;
            $display("FAIL t3_grant_order: got %s, expected %s", order, exp_order);
        end
        wait_idle;

        // Backpressure on port A while B waits
        a_rready = 1'b0;
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 8'h00;
        b_valid = 1'b1; b_rw = 1'b0; b_addr = 8'h05;
        @(negedge clk);
        check("t4_a_ready", 32'(a_ready), 32'd1);
        tick;
        a_valid = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_rvalid", 32'(a_rvalid), 32'd1);
            check("t4_hold_rdata",  32'(a_rdata),  32'h0081);
            check("t4_b_ready_low", 32'(b_ready),  32'd0);
            tick;
        end
        a_rready = 1'b1;
        @(negedge clk);
        check("t4_handshake_b_ready", 32'(b_ready), 32'd0);
        tick;
        @(negedge clk);
        check("t4_b_granted", 32'(b_ready), 32'd1);
        tick;
        b_valid = 1'b0;
        wait_idle;

        // Reset landing on the ISSUE edge of a write
        a_valid = 1'b1; a_rw = 1'b1; a_addr = 8'h10; a_wdata = 16'hBEEF;
        @(negedge clk);
        check("t5_a_ready", 32'(a_ready), 32'd1);
        tick;
        a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_issue_rw", 32'(mem_rw), 32'd1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy",     32'(busy),      32'd0);
        check("t5_mem_rw",   32'(mem_rw),    32'd0);
        check("t5_mem_addr", 32'(mem_addr),  32'd0);
        check("t5_mem_data", 32'(mem_wdata), 32'd0);
        check("t5_a_rvalid", 32'(a_rvalid),  32'd0);
        check("t5_b_rvalid", 32'(b_rvalid),  32'd0);
        check("t5_mem_cell", 32'(mem[8'h10]), 32'hBEEF);
        tick;
        @(negedge clk);
        check("t5_no_rvalid", 32'(a_rvalid), 32'd0);
        tick;
        req(1'b0, 1'b0, 8'h10, 16'h0000, rd, rwc);
        check("t5_readback", 32'(rd), 32'hBEEF);

        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
